// File: rtl/lut_div_pkg.sv
// Shared types and elaboration-time helpers for the constant-divisor radix-4 divider.
package lut_div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned DIV_W = 16;
    localparam int unsigned STEPS = 8;
    localparam int unsigned A_MIN = 1;
    localparam int unsigned A_MAX = 4095;

    // k*a reduced to the rw+2 bit width of the trial-remainder datapath
    function automatic int unsigned lut_multiple(input int unsigned a, input int unsigned k,
                                                 input int unsigned rw);
        return (a * k) % (32'd1 << (rw + 2));
    endfunction

endpackage

// File: rtl/lut_div_digit.sv
// One radix-4 step: compare the trial remainder against 1A/2A/3A, pick the digit, subtract.
module lut_div_digit
    import lut_div_pkg::*;
#(
    parameter int unsigned RW = 12
) (
    input  logic [RW+1:0] i_t,
    input  logic [RW+1:0] i_m1,
    input  logic [RW+1:0] i_m2,
    input  logic [RW+1:0] i_m3,
    output logic [1:0]    o_q,
    output logic [RW-1:0] o_r
);

    logic [RW+1:0] w_sub;

    always_comb begin
        o_q   = 2'd0;
        w_sub = '0;
        if (i_t >= i_m3) begin
            o_q   = 2'd3;
            w_sub = i_m3;
        end else if (i_t >= i_m2) begin
            o_q   = 2'd2;
            w_sub = i_m2;
        end else if (i_t >= i_m1) begin
            o_q   = 2'd1;
            w_sub = i_m1;
        end
    end

    // t - q*A < A, so the top two bits of the difference are always zero
    assign o_r = RW'(i_t - w_sub);

endmodule

// File: rtl/lut_div_const_seq.sv
// Sequential divider by a compile-time constant: one radix-4 quotient digit per cycle,
// valid/ready handshake on both sides, result held until accepted.
module lut_div_const_seq
    import lut_div_pkg::*;
#(
    parameter int unsigned A_const = 2,
    parameter int unsigned RW      = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [DIV_W-1:0] i_dividend,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [DIV_W-1:0] o_quotient,
    output logic [RW-1:0]    o_remainder
);

    if ((A_const < A_MIN) || (A_const > A_MAX)) begin : g_bad_a
        $error("lut_div_const_seq: A_const %0d outside 1..4095", A_const);
    end
    if ((RW < 1) || ((A_const - 1) >= (64'd1 << RW))) begin : g_bad_rw
        $error("lut_div_const_seq: RW %0d cannot hold A_const-1", RW);
    end

    localparam logic [RW+1:0] M1 = (RW + 2)'(lut_multiple(A_const, 1, RW));
    localparam logic [RW+1:0] M2 = (RW + 2)'(lut_multiple(A_const, 2, RW));
    localparam logic [RW+1:0] M3 = (RW + 2)'(lut_multiple(A_const, 3, RW));

    state_e           r_state;
    logic [DIV_W-1:0] r_d;
    logic [RW-1:0]    r_r;
    logic [DIV_W-1:0] r_q;
    logic [2:0]       r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [RW+1:0]    w_t;
    logic [1:0]       w_q;
    logic [RW-1:0]    w_r_next;

    assign w_t = {r_r, r_d[DIV_W-1:DIV_W-2]};

    lut_div_digit #(
        .RW (RW)
    ) u_digit (
        .i_t  (w_t),
        .i_m1 (M1),
        .i_m2 (M2),
        .i_m3 (M3),
        .o_q  (w_q),
        .o_r  (w_r_next)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_d         <= '0;
            r_r         <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        r_d        <= i_dividend;
                        r_r        <= '0;
                        r_q        <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= StRun;
                    end
                end
                StRun: begin
                    r_r   <= w_r_next;
                    r_d   <= {r_d[DIV_W-3:0], 2'b00};
                    r_q   <= {r_q[DIV_W-3:0], w_q};
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'(STEPS - 1)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end
                end
                StDone: begin
                    // Q and R are untouched here, so the result stays stable under backpressure
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_quotient  = r_q;
    assign o_remainder = r_r;

endmodule

// File: tb/tb_lut_div_const_seq.sv
// Directed and randomized checks of lut_div_const_seq over several divisor constants,
// compared against plain integer division.
module tb_lut_div_const_seq;

    localparam int NI = 7;
    localparam int unsigned AV [NI] = '{2, 7, 1, 4095, 3, 5, 13};

    logic        clk;
    logic        rst;
    logic        in_valid  [NI];
    logic        in_ready  [NI];
    logic [15:0] dividend  [NI];
    logic        out_valid [NI];
    logic        out_ready [NI];
    logic [15:0] quotient  [NI];
    logic [11:0] remainder [NI];

    int n_vec;
    int n_err;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        lut_div_const_seq #(
            .A_const (AV[g]),
            .RW      (12)
        ) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_in_valid  (in_valid[g]),
            .o_in_ready  (in_ready[g]),
            .i_dividend  (dividend[g]),
            .o_out_valid (out_valid[g]),
            .i_out_ready (out_ready[g]),
            .o_quotient  (quotient[g]),
            .o_remainder (remainder[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance k; results are checked against dv / A and dv % A.
    task automatic run_op(input int k, input logic [15:0] dv, input int stall);
        int unsigned exp_q;
        int unsigned exp_r;
        int          lat;
        exp_q = 32'(dv) / AV[k];
        exp_r = 32'(dv) % AV[k];
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready[k]), 32'd1);
        in_valid[k]  = 1'b1;
        dividend[k]  = dv;
        out_ready[k] = (stall == 0);
        @(negedge clk);
        in_valid[k] = 1'b0;
        dividend[k] = 16'($urandom);
        chk("in_ready_run", 32'(in_ready[k]), 32'd0);
        lat = 1;
        while (!out_valid[k] && lat < 40) begin
            @(negedge clk);
            lat++;
            dividend[k] = 16'($urandom);
        end
        chk("latency", 32'(lat), 32'd9);
        chk("quotient", 32'(quotient[k]), exp_q);
        chk("remainder", 32'(remainder[k]), exp_r);
        chk("in_ready_done", 32'(in_ready[k]), 32'd0);
        for (int i = 0; i < stall; i++) begin
            chk("hold_valid", 32'(out_valid[k]), 32'd1);
            chk("hold_in_ready", 32'(in_ready[k]), 32'd0);
            chk("hold_quotient", 32'(quotient[k]), exp_q);
            chk("hold_remainder", 32'(remainder[k]), exp_r);
            in_valid[k] = 1'b1;
            dividend[k] = 16'($urandom);
            @(negedge clk);
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        @(negedge clk);
        chk("in_ready_after", 32'(in_ready[k]), 32'd1);
        chk("out_valid_after", 32'(out_valid[k]), 32'd0);
        out_ready[k] = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        for (int k = 0; k < NI; k++) begin
            in_valid[k]  = 1'b0;
            dividend[k]  = '0;
            out_ready[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_in_ready", 32'(in_ready[k]), 32'd1);
            chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
            chk("rst_quotient", 32'(quotient[k]), 32'd0);
            chk("rst_remainder", 32'(remainder[k]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        run_op(0, 16'd200, 0);
        run_op(1, 16'd100, 0);
        run_op(1, 16'hFFFF, 0);
        run_op(2, 16'hABCD, 0);
        run_op(3, 16'd4094, 0);
        run_op(3, 16'hFFFF, 1);
        run_op(4, 16'd1000, 20);

        // Reset in RUN cycle 4 must abort without an output pulse
        @(negedge clk);
        in_valid[5]  = 1'b1;
        dividend[5]  = 16'($urandom);
        out_ready[5] = 1'b1;
        @(negedge clk);
        in_valid[5] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready[5]), 32'd1);
        chk("abort_out_valid", 32'(out_valid[5]), 32'd0);
        chk("abort_quotient", 32'(quotient[5]), 32'd0);
        rst          = 1'b0;
        out_ready[5] = 1'b0;
        run_op(5, 16'd50, 0);

        for (int x = 0; x < 256; x++) begin
            run_op(6, 16'(x * 13), 0);
        end

        for (int n = 0; n < 10; n++) begin
            for (int k = 0; k < NI; k++) begin
                run_op(k, 16'($urandom), int'($urandom_range(0, 3)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lut_div_const_seq.md
# lut_div_const_seq

Sequential divider by a compile-time constant, the inverse of the LUT constant multiplier. It takes a 16-bit dividend and returns the 16-bit quotient and the remainder of division by `A_const`. It uses a 3-word multiple LUT (1A, 2A, 3A) and retires one radix-4 quotient digit per cycle. It sits downstream of the multiplier datapath and recovers X from C = X*A; it also serves as a self-check path in multiplier benches.

## Interface
- `A_const`, default 2: divisor constant; legal range 1..4095; elaboration error outside this range.
- `RW`, default 12: remainder width; must hold A_const-1.

- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  dividend offered
- `in_ready`  out  1  block can accept a dividend
- `dividend`  in  16  unsigned dividend, sampled when in_valid && in_ready
- `out_valid`  out  1  result held stable
- `out_ready`  in  1  consumer accepts result
- `quotient`  out  16  floor(dividend / A_const)
- `remainder`  out  RW  dividend mod A_const

## Operation
- FSM has three states:
  - IDLE: in_ready=1. On in_valid, load dividend into shift register D, clear partial remainder R and quotient register Q, clear counter cnt (3 bits), then go to RUN.
  - RUN: in_ready=0. Each cycle:
    - t = {R, D[15:14]}, RW+2 bits wide.
    - Digit q: 3 if t>=3A, else 2 if t>=2A, else 1 if t>=A, else 0.
    - Update R <= t - q*A, D <= D<<2, Q <= {Q[13:0], q}, cnt <= cnt+1.
    - After the 8th step (cnt==7), go to DONE.
  - DONE: out_valid=1; quotient=Q, remainder=R[RW-1:0]. On out_ready, go to IDLE.
- LUT constants M1=A, M2=2A, M3=3A are elaboration-time values of width RW+2, not runtime multiplies.
- Invariant R < A holds after every step, so t < 4A always fits RW+2 bits.
- A_const==1: every digit equals the dividend bit pair; quotient=dividend, remainder=0.
- in_valid is ignored outside IDLE. There is no queuing: the source holds in_valid until in_ready.
- The dividend is captured at acceptance; changes on `dividend` during RUN do not affect the result.
- quotient and remainder hold their values across DONE until the handshake completes, even if out_ready stays low indefinitely.

## Timing
- Reset (asynchronous assert, synchronous release at the next edge): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, internal D/R/cnt=0.
- Acceptance edge = cycle 0. RUN spans cycles 1..8. out_valid rises after edge 8, so it is visible in cycle 9 (latency 9 cycles from accept to out_valid).
- If out_ready is already high in cycle 9, the result transfers that cycle and in_ready=1 in cycle 10. Minimum initiation interval is 10 cycles.
- in_ready and out_valid are never high together. A simultaneous in_valid in the DONE cycle is not accepted.
- Reset mid-RUN or mid-DONE aborts the operation immediately, with no output pulse. The first accept after reset release behaves as a fresh operation.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid/out_ready to in_ready/out_valid.

## Structure
- Package `lut_div_pkg`:
  - state enum {IDLE, RUN, DONE}
  - DIV_W=16, STEPS=8
  - function computing the M1/M2/M3 constants from A_const and RW
- One sub-module `lut_div_digit`, purely combinational. It takes t and the three multiples and returns the 2-bit digit q and the next R. The top module holds the FSM, registers and handshake.

## Test plan
- A_const=2, dividend=200, out_ready=1 → out_valid in cycle 9 after accept, quotient=100, remainder=0, in_ready back high the next cycle.
- A_const=7, dividend=100 → quotient=14, remainder=2. Then dividend=16'hFFFF → quotient=9362, remainder=1.
- A_const=1, dividend=16'hABCD → quotient=16'hABCD, remainder=0. A_const=4095, dividend=4094 → quotient=0, remainder=4094.
- Backpressure with A_const=3, dividend=1000: hold out_ready=0 for 20 cycles → out_valid stays 1 with quotient=333, remainder=1 stable; in_ready stays 0; a new in_valid is not accepted until after out_ready.
- Assert rst in RUN cycle 4 → in_ready=1, out_valid=0, quotient=0 next sample. A new dividend=50 with A_const=5 gives quotient=10, remainder=0 at normal latency.
- Loopback with the multiplier: for X in 0..255, C=X*A (A_const=13) fed back-to-back → quotient=X, remainder=0 for all 256 inputs.
